// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: N-bit unsigned binary to D packed BCD digits, one bit per clock.
// Result appears N cycles after accept; o_ready is low while converting and requests arriving then are dropped.
module bin_to_bcd_seq #(
  parameter int N = 16,
  parameter int D = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_valid,
  input  logic [N-1:0]   i_bin,
  output logic           o_ready,
  output logic           o_valid,
  output logic [4*D-1:0] o_bcd
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [4*D+N-1:0]   sr;
  logic [4*D-1:0]     bcd_adj;
  logic [4*D+N-1:0]   sr_next;

  // Add-3 correction on every BCD digit, then shift the whole {BCD, binary} register.
  always_comb begin
    bcd_adj = sr[4*D+N-1:N];
    for (int k = 0; k < D; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
      end
    end
    sr_next = {bcd_adj, sr[N-1:0]} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      cnt     <= '0;
      sr      <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            sr      <= {{(4*D){1'b0}}, i_bin};
            cnt     <= '0;
            state   <= CONV;
            o_ready <= 1'b0;
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            o_bcd   <= sr_next[4*D+N-1:N];
            o_valid <= 1'b1;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected BCD pushed on accept, popped and checked on o_valid.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_bin = '0;
  logic        o_ready;
  logic        o_valid;
  logic [19:0] o_bcd;

  typedef struct {
    logic [19:0] bcd;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.N(16), .D(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_bin   (i_bin),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_bcd   (o_bcd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic bad_digit(input logic [19:0] b);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (b[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Output monitor: every o_valid must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o_valid) begin
      n_valid++;
      vcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("bcd", 32'(o_bcd), 32'(e.bcd));
        chk("latency", 32'(cyc - e.acc), 32'd16);
      end
      chk("digit_range", 32'(bad_digit(o_bcd)), 32'd0);
      chk("ready_with_valid", 32'(o_ready), 32'd1);
    end
  end

  // Call at a falling edge; waits for o_ready, then presents v for one cycle.
  task automatic send(input logic [15:0] v);
    int w;
    w = 0;
    while (!o_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_bin   = v;
    sb.push_back('{bcd: ref_bcd(32'(v)), acc: cyc + 1});
    @(negedge clk);
    i_valid = 1'b0;
    chk("ready_low", 32'(o_ready), 32'd0);
  endtask

  task automatic wait_done();
    for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int vq;
    int a0;
    int a1;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_bcd", 32'(o_bcd), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed values, including zero and the maximum.
    send(16'h0000); wait_done();
    send(16'hFE01); wait_done();
    chk("bcd_65025", 32'(o_bcd), 32'h65025);
    send(16'hFFFF); wait_done();
    chk("bcd_65535", 32'(o_bcd), 32'h65535);
    send(16'h270F); wait_done();

    // Back-to-back with i_valid held: second accept lands one cycle after the first o_valid.
    v0 = n_valid;
    vq = vcyc.size();
    a0 = 0;
    a1 = 0;
    n  = 0;
    i_valid = 1'b1;
    i_bin   = 16'd1;
    for (int c = 0; c < 60 && n < 2; c++) begin
      if (o_ready) begin
        sb.push_back('{bcd: ref_bcd(32'(i_bin)), acc: cyc + 1});
        if (n == 0) a0 = cyc + 1;
        else        a1 = cyc + 1;
        n++;
      end
      @(negedge clk);
      if (n == 1) i_bin = 16'd10;
    end
    i_valid = 1'b0;
    wait_done();
    chk("b2b_valids", 32'(n_valid - v0), 32'd2);
    chk("b2b_gap", 32'(a1 - a0), 32'd17);
    chk("b2b_accept_after_valid", 32'(a1 - ((vcyc.size() > vq) ? vcyc[vq] : 0)), 32'd1);

    // Requests during CONV are dropped.
    v0 = n_valid;
    send(16'h1234);
    for (int c = 0; c < 12; c++) begin
      i_valid = (c % 2 == 0);
      i_bin   = 16'hFFFF;
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("ignore_valids", 32'(n_valid - v0), 32'd1);
    chk("hold_bcd", 32'(o_bcd), 32'h04660);

    // Reset on cycle 8 of CONV, with a simultaneous request that must lose to reset.
    v0 = n_valid;
    send(16'h3039);
    repeat (6) @(negedge clk);
    chk("hold_in_conv", 32'(o_bcd), 32'h04660);
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b1;
    i_bin   = 16'h3039;
    sb.delete();
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
    chk("abort_bcd", 32'(o_bcd), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_valid", 32'(o_valid), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_no_valid", 32'(n_valid - v0), 32'd0);
    send(16'h3039); wait_done();
    chk("bcd_12345", 32'(o_bcd), 32'h12345);

    // Random sweep; i_bin is scrambled after each accept.
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom));
      i_bin = 16'($urandom);
    end
    wait_done();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
